uart_word_bridge: RTL and testbench

- Parametrised bridge between word-wide buffers and a byte-wide UART core (JTAG UART or physical UART behind a valid/ready byte port).
- TX path: pops words from the readin buffer and serialises them into bytes.
- RX path: assembles received bytes into words and pushes them to the writeout buffer.
- TX and RX run concurrently and independently. Byte order and word width are configurable. A timeout flushes partial receive words.

---
 rtl/uart_word_bridge_pkg.sv | 33 +++
 rtl/uart_word_bridge_if.sv | 20 ++
 rtl/uart_word_serializer.sv | 84 ++++++++
 rtl/uart_word_bridge.sv | 123 ++++++++++++
 tb/tb_uart_word_bridge.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_word_bridge_pkg.sv
// Shared types and helpers for the word/byte UART bridge.
// The byte-lane function keeps the TX and RX byte ordering rules in one place.
package uart_bridge_pkg;

    typedef enum logic {
        T_IDLE = 1'b0,
        T_SEND = 1'b1
    } tx_state_t;

    typedef enum logic {
        R_COLLECT = 1'b0,
        R_PUSH    = 1'b1
    } rx_state_t;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_BYTES  = DEF_DATA_W / 8;

    function automatic int unsigned bytes_of(input int unsigned data_w);
        return data_w / 8;
    endfunction

    // A single-byte word still needs a 1-bit counter.
    function automatic int unsigned cnt_w(input int unsigned bytes);
        return (bytes <= 1) ? 1 : $clog2(bytes);
    endfunction

    function automatic int unsigned byte_lane(input int unsigned idx,
                                              input int unsigned bytes,
                                              input bit          msb_first);
        return msb_first ? (bytes - 1 - idx) : idx;
    endfunction

endpackage

// File: rtl/uart_word_bridge_if.sv
// Byte-wide valid/ready link between the bridge and the UART core.
// master = bridge side, slave = UART core side.
interface uart_word_bridge_if;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ready;

    modport master (
        output tx_byte, tx_valid, rx_ready,
        input  tx_ready, rx_byte, rx_valid
    );

    modport slave (
        input  tx_byte, tx_valid, rx_ready,
        output tx_ready, rx_byte, rx_valid
    );
endinterface

// File: rtl/uart_word_serializer.sv
// TX path: pops words from the show-ahead readin buffer and shifts them out a byte at a time.
// The next word is popped on the cycle the last byte is accepted so consecutive words have no gap.
module uart_word_serializer
    import uart_bridge_pkg::*;
#(
    parameter int unsigned DATA_W       = 32,
    parameter bit          TX_MSB_FIRST = 1'b0
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              empty_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              read_o,
    output logic [7:0]        tx_byte_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output logic              busy_o
);

    localparam int unsigned BYTES    = bytes_of(DATA_W);
    localparam int unsigned CW       = cnt_w(BYTES);
    localparam int unsigned OUT_LANE = byte_lane(0, BYTES, TX_MSB_FIRST);
    localparam logic [CW-1:0] LAST   = CW'(BYTES - 1);

    tx_state_t         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              accept;
    logic              pop;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= T_IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        accept  = (state_q == T_SEND) && tx_ready_i;
        case (state_q)
            T_IDLE: begin
                if (!empty_i) pop = 1'b1;
            end
            T_SEND: begin
                if (accept) begin
                    if (cnt_q == LAST) begin
                        cnt_d = '0;
                        if (!empty_i) begin
                            pop = 1'b1;
                        end else begin
                            state_d = T_IDLE;
                            shift_d = '0;
                        end
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        shift_d = TX_MSB_FIRST ? (shift_q << 8) : (shift_q >> 8);
                    end
                end
            end
            default: state_d = T_IDLE;
        endcase
        if (pop) begin
            shift_d = data_i;
            cnt_d   = '0;
            state_d = T_SEND;
        end
    end

    // Gated so the pop strobe reads 0 while reset is held, whatever empty_i does.
    assign read_o     = pop & ~reset_i;
    assign tx_valid_o = (state_q == T_SEND);
    assign tx_byte_o  = shift_q[OUT_LANE*8 +: 8];
    assign busy_o     = (state_q != T_IDLE);

endmodule

// File: rtl/uart_word_bridge.sv
// Word-wide buffer <-> byte-wide UART bridge. TX lives in uart_word_serializer; the RX
// assembler, its writeout push and the partial-word timeout flush live here.
module uart_word_bridge
    import uart_bridge_pkg::*;
#(
    parameter int unsigned DATA_W       = 32,
    parameter bit          TX_MSB_FIRST = 1'b0,
    parameter bit          RX_MSB_FIRST = 1'b1,
    parameter int unsigned RX_TIMEOUT   = 0,
    parameter int unsigned TO_W         = 16
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              empty_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              read_o,
    input  logic              full_i,
    output logic              write_o,
    output logic [DATA_W-1:0] data_o,
    output logic              rx_flush_o,
    output logic              busy_o,
    uart_word_bridge_if.master uart_io
);

    localparam int unsigned BYTES      = bytes_of(DATA_W);
    localparam int unsigned CW         = cnt_w(BYTES);
    localparam logic [CW-1:0]   LAST   = CW'(BYTES - 1);
    localparam logic [TO_W-1:0] TO_LIM = TO_W'(RX_TIMEOUT);

    logic tx_busy;

    uart_word_serializer #(
        .DATA_W       (DATA_W),
        .TX_MSB_FIRST (TX_MSB_FIRST)
    ) u_ser (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .empty_i    (empty_i),
        .data_i     (data_i),
        .read_o     (read_o),
        .tx_byte_o  (uart_io.tx_byte),
        .tx_valid_o (uart_io.tx_valid),
        .tx_ready_i (uart_io.tx_ready),
        .busy_o     (tx_busy)
    );

    rx_state_t         rx_state_q, rx_state_d;
    logic [DATA_W-1:0] asm_q, asm_d;
    logic [CW-1:0]     rx_cnt_q, rx_cnt_d;
    logic [TO_W-1:0]   idle_q, idle_d;
    logic              flush_q, flush_d;
    logic              rx_accept;
    logic              push;
    int unsigned       lane;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            rx_state_q <= R_COLLECT;
            asm_q      <= '0;
            rx_cnt_q   <= '0;
            idle_q     <= '0;
            flush_q    <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            asm_q      <= asm_d;
            rx_cnt_q   <= rx_cnt_d;
            idle_q     <= idle_d;
            flush_q    <= flush_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        asm_d      = asm_q;
        rx_cnt_d   = rx_cnt_q;
        idle_d     = idle_q;
        flush_d    = flush_q;
        push       = 1'b0;
        rx_accept  = (rx_state_q == R_COLLECT) && uart_io.rx_valid;
        lane       = byte_lane(32'(rx_cnt_q), BYTES, RX_MSB_FIRST);
        case (rx_state_q)
            R_COLLECT: begin
                if (rx_accept) begin
                    for (int unsigned l = 0; l < BYTES; l++) begin
                        if (l == lane) asm_d[l*8 +: 8] = uart_io.rx_byte;
                    end
                    idle_d = '0;
                    if (rx_cnt_q == LAST) begin
                        rx_cnt_d   = '0;
                        rx_state_d = R_PUSH;
                    end else begin
                        rx_cnt_d = rx_cnt_q + 1'b1;
                    end
                end else if (RX_TIMEOUT != 0 && rx_cnt_q != '0) begin
                    // Unfilled lanes are already zero: the register is cleared on every push.
                    idle_d = idle_q + 1'b1;
                    if (idle_d == TO_LIM) begin
                        idle_d     = '0;
                        rx_cnt_d   = '0;
                        flush_d    = 1'b1;
                        rx_state_d = R_PUSH;
                    end
                end
            end
            R_PUSH: begin
                if (!full_i) begin
                    push       = 1'b1;
                    asm_d      = '0;
                    flush_d    = 1'b0;
                    rx_state_d = R_COLLECT;
                end
            end
            default: rx_state_d = R_COLLECT;
        endcase
    end

    assign uart_io.rx_ready = (rx_state_q == R_COLLECT) & ~reset_i;
    assign write_o          = push;
    assign data_o           = asm_q;
    assign rx_flush_o       = push & flush_q;
    assign busy_o           = tx_busy | (rx_state_q == R_PUSH) | (rx_cnt_q != '0);

endmodule

// File: tb/tb_uart_word_bridge.sv
// Directed bench for uart_word_bridge: 32-bit words, TX LSB-first, RX MSB-first, 10-cycle RX timeout.
module tb_uart_word_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        empty = 1'b1;
    logic [31:0] din = '0;
    logic        rd;
    logic        full = 1'b0;
    logic        wr;
    logic [31:0] dout;
    logic        flush;
    logic        busy;
    int          checks = 0;
    int          failures = 0;

    uart_word_bridge_if u_if ();

    uart_word_bridge #(
        .DATA_W       (32),
        .TX_MSB_FIRST (1'b0),
        .RX_MSB_FIRST (1'b1),
        .RX_TIMEOUT   (10),
        .TO_W         (16)
    ) dut (
        .clock_i    (clk),
        .reset_i    (rst),
        .empty_i    (empty),
        .data_i     (din),
        .read_o     (rd),
        .full_i     (full),
        .write_o    (wr),
        .data_o     (dout),
        .rx_flush_o (flush),
        .busy_o     (busy),
        .uart_io    (u_if)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        u_if.tx_ready = 1'b0;
        u_if.rx_valid = 1'b0;
        u_if.rx_byte  = 8'h00;
        din   = 32'hDEADBEEF;
        empty = 1'b0;
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (rd !== 1'b0) begin failures++; $display("FAIL reset_read got=%b exp=0", rd); end
        checks++; if (u_if.tx_valid !== 1'b0 || u_if.tx_byte !== 8'h00) begin failures++; $display("FAIL reset_tx got=%b/%h exp=0/00", u_if.tx_valid, u_if.tx_byte); end
        checks++; if (u_if.rx_ready !== 1'b0) begin failures++; $display("FAIL reset_rx_ready got=%b exp=0", u_if.rx_ready); end
        checks++; if (wr !== 1'b0 || dout !== 32'h0 || flush !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_outs got wr=%b dout=%h flush=%b busy=%b exp all 0", wr, dout, flush, busy); end
        empty = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (u_if.rx_ready !== 1'b1) begin failures++; $display("FAIL post_reset_rx_ready got=%b exp=1", u_if.rx_ready); end
        checks++; if (busy !== 1'b0 || rd !== 1'b0) begin failures++; $display("FAIL post_reset_idle got busy=%b rd=%b exp=0/0", busy, rd); end
        step();
    endtask

    task automatic test_tx_lsb();
        logic [7:0] exp [4];
        exp = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
        din = 32'hAABBCCDD;
        empty = 1'b0;
        u_if.tx_ready = 1'b1;
        @(negedge clk);
        checks++; if (rd !== 1'b1) begin failures++; $display("FAIL tx_pop got=%b exp=1", rd); end
        checks++; if (u_if.tx_valid !== 1'b0) begin failures++; $display("FAIL tx_pop_latency tx_valid got=%b exp=0", u_if.tx_valid); end
        step();
        empty = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (u_if.tx_valid !== 1'b1 || u_if.tx_byte !== exp[i] || rd !== 1'b0) begin
                failures++; $display("FAIL tx_lsb_byte%0d got v=%b b=%h rd=%b exp v=1 b=%h rd=0", i, u_if.tx_valid, u_if.tx_byte, rd, exp[i]);
            end
            step();
        end
        @(negedge clk);
        checks++; if (u_if.tx_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL tx_done got v=%b busy=%b exp=0/0", u_if.tx_valid, busy); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] q [$];
        logic [7:0]  exp [8];
        logic [15:0] rdy_pat;
        logic [7:0]  prev_byte;
        logic        prev_stall;
        logic        started;
        logic        pop;
        int          nbytes;
        q = '{32'h01020304, 32'h05060708};
        exp = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h08, 8'h07, 8'h06, 8'h05};
        rdy_pat = 16'b1101_1011_0111_0101;
        prev_byte = 8'h00;
        prev_stall = 1'b0;
        started = 1'b0;
        nbytes = 0;
        for (int cyc = 0; cyc < 60 && nbytes < 8; cyc++) begin
            empty = (q.size() == 0);
            din = (q.size() != 0) ? q[0] : 32'h0;
            u_if.tx_ready = rdy_pat[cyc % 16];
            @(negedge clk);
            if (rd === 1'b1 && empty) begin
                checks++; failures++; $display("FAIL b2b_pop_when_empty cyc=%0d got rd=1 exp=0", cyc);
            end
            if (prev_stall) begin
                checks++;
                if (u_if.tx_byte !== prev_byte) begin failures++; $display("FAIL b2b_stall_stable cyc=%0d got=%h exp=%h", cyc, u_if.tx_byte, prev_byte); end
            end
            if (started) begin
                checks++;
                if (u_if.tx_valid !== 1'b1) begin failures++; $display("FAIL b2b_bubble cyc=%0d tx_valid got=0 exp=1", cyc); end
            end
            if (u_if.tx_valid === 1'b1) started = 1'b1;
            if (u_if.tx_valid === 1'b1 && u_if.tx_ready === 1'b1) begin
                checks++;
                if (u_if.tx_byte !== exp[nbytes]) begin failures++; $display("FAIL b2b_byte%0d got=%h exp=%h", nbytes, u_if.tx_byte, exp[nbytes]); end
                nbytes++;
            end
            prev_stall = u_if.tx_valid && !u_if.tx_ready;
            prev_byte = u_if.tx_byte;
            pop = rd;
            step();
            if (pop && q.size() != 0) void'(q.pop_front());
        end
        checks++; if (nbytes != 8) begin failures++; $display("FAIL b2b_byte_count got=%0d exp=8", nbytes); end
        empty = 1'b1;
        u_if.tx_ready = 1'b1;
        @(negedge clk);
        checks++; if (u_if.tx_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL b2b_idle got v=%b busy=%b exp=0/0", u_if.tx_valid, busy); end
        step();
    endtask

    task automatic send_rx(input logic [7:0] b, input string name);
        u_if.rx_valid = 1'b1;
        u_if.rx_byte = b;
        @(negedge clk);
        checks++; if (u_if.rx_ready !== 1'b1 || wr !== 1'b0) begin failures++; $display("FAIL %s_accept_%h got rdy=%b wr=%b exp=1/0", name, b, u_if.rx_ready, wr); end
        step();
    endtask

    task automatic test_rx_msb();
        full = 1'b0;
        send_rx(8'h12, "rx_msb"); send_rx(8'h34, "rx_msb"); send_rx(8'h56, "rx_msb"); send_rx(8'h78, "rx_msb");
        u_if.rx_valid = 1'b0;
        @(negedge clk);
        checks++; if (wr !== 1'b1 || dout !== 32'h12345678 || flush !== 1'b0) begin failures++; $display("FAIL rx_msb_push got wr=%b d=%h fl=%b exp 1/12345678/0", wr, dout, flush); end
        step();
        @(negedge clk);
        checks++; if (wr !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rx_msb_after got wr=%b busy=%b exp=0/0", wr, busy); end
        step();
    endtask

    task automatic test_rx_backpressure();
        full = 1'b1;
        send_rx(8'h9A, "rx_bp"); send_rx(8'hBC, "rx_bp"); send_rx(8'hDE, "rx_bp"); send_rx(8'hF0, "rx_bp");
        u_if.rx_valid = 1'b1;
        u_if.rx_byte = 8'h11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (u_if.rx_ready !== 1'b0 || wr !== 1'b0 || dout !== 32'h9ABCDEF0) begin
                failures++; $display("FAIL rx_bp_hold%0d got rdy=%b wr=%b d=%h exp 0/0/9abcdef0", i, u_if.rx_ready, wr, dout);
            end
            step();
        end
        full = 1'b0;
        @(negedge clk);
        checks++; if (wr !== 1'b1 || dout !== 32'h9ABCDEF0 || u_if.rx_ready !== 1'b0) begin failures++; $display("FAIL rx_bp_release got wr=%b d=%h rdy=%b exp 1/9abcdef0/0", wr, dout, u_if.rx_ready); end
        step();
        send_rx(8'h11, "rx_bp_next"); send_rx(8'h22, "rx_bp_next"); send_rx(8'h33, "rx_bp_next"); send_rx(8'h44, "rx_bp_next");
        u_if.rx_valid = 1'b0;
        @(negedge clk);
        checks++; if (wr !== 1'b1 || dout !== 32'h11223344) begin failures++; $display("FAIL rx_bp_next_word got wr=%b d=%h exp 1/11223344", wr, dout); end
        step();
    endtask

    task automatic test_timeout();
        logic        seen;
        int          k_seen;
        logic [31:0] d;
        logic        f;
        seen = 1'b0; k_seen = 0; d = '0; f = 1'b0;
        send_rx(8'hAB, "to"); send_rx(8'hCD, "to");
        u_if.rx_valid = 1'b0;
        for (int k = 1; k <= 30 && !seen; k++) begin
            @(negedge clk);
            if (wr === 1'b1) begin seen = 1'b1; k_seen = k; d = dout; f = flush; end
            step();
        end
        checks++; if (!seen) begin failures++; $display("FAIL to_no_push got none within 30 cycles exp push"); end
        checks++; if (k_seen != 11) begin failures++; $display("FAIL to_latency got=%0d exp=11", k_seen); end
        checks++; if (d !== 32'hABCD0000 || f !== 1'b1) begin failures++; $display("FAIL to_word got d=%h fl=%b exp abcd0000/1", d, f); end
        @(negedge clk);
        checks++; if (wr !== 1'b0 || flush !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL to_after got wr=%b fl=%b busy=%b exp 0/0/0", wr, flush, busy); end
        step();
        // Byte lands on the 10th idle slot: it must be taken and the flush cancelled.
        send_rx(8'h01, "to_cancel"); send_rx(8'h02, "to_cancel");
        u_if.rx_valid = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            checks++; if (wr !== 1'b0) begin failures++; $display("FAIL to_cancel_idle%0d got wr=1 exp=0", k); end
            step();
        end
        send_rx(8'h03, "to_cancel");
        send_rx(8'h04, "to_cancel");
        u_if.rx_valid = 1'b0;
        @(negedge clk);
        checks++; if (wr !== 1'b1 || dout !== 32'h01020304 || flush !== 1'b0) begin failures++; $display("FAIL to_cancel_word got wr=%b d=%h fl=%b exp 1/01020304/0", wr, dout, flush); end
        step();
    endtask

    task automatic test_reset_mid();
        logic [7:0] txe [4];
        logic [7:0] rxb [4];
        txe = '{8'h88, 8'h77, 8'h66, 8'h55};
        rxb = '{8'hB2, 8'hC3, 8'hD4, 8'h00};
        din = 32'h11223344;
        empty = 1'b0;
        u_if.tx_ready = 1'b1;
        u_if.rx_valid = 1'b1;
        u_if.rx_byte = 8'hC1;
        step();
        empty = 1'b1;
        u_if.rx_byte = 8'hC2;
        step();
        u_if.rx_byte = 8'hC3;
        step();
        u_if.tx_ready = 1'b0;
        u_if.rx_valid = 1'b0;
        checks++; if (u_if.tx_valid !== 1'b1 || u_if.tx_byte !== 8'h22 || dout !== 32'hC1C2C300 || busy !== 1'b1) begin
            failures++; $display("FAIL mid_state got v=%b b=%h d=%h busy=%b exp 1/22/c1c2c300/1", u_if.tx_valid, u_if.tx_byte, dout, busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++; if (u_if.tx_valid !== 1'b0 || u_if.tx_byte !== 8'h00 || rd !== 1'b0) begin failures++; $display("FAIL mid_reset_tx got v=%b b=%h rd=%b exp 0/00/0", u_if.tx_valid, u_if.tx_byte, rd); end
        checks++; if (dout !== 32'h0 || wr !== 1'b0 || busy !== 1'b0 || u_if.rx_ready !== 1'b0) begin failures++; $display("FAIL mid_reset_rx got d=%h wr=%b busy=%b rdy=%b exp 0/0/0/0", dout, wr, busy, u_if.rx_ready); end
        @(posedge clk);
        #1 rst = 1'b0;
        din = 32'h55667788;
        empty = 1'b0;
        u_if.tx_ready = 1'b1;
        u_if.rx_valid = 1'b1;
        u_if.rx_byte = 8'hA1;
        @(negedge clk);
        checks++; if (rd !== 1'b1 || u_if.rx_ready !== 1'b1) begin failures++; $display("FAIL mid_restart got rd=%b rdy=%b exp 1/1", rd, u_if.rx_ready); end
        step();
        empty = 1'b1;
        for (int i = 0; i < 4; i++) begin
            u_if.rx_valid = (i < 3);
            u_if.rx_byte = rxb[i];
            @(negedge clk);
            checks++;
            if (u_if.tx_valid !== 1'b1 || u_if.tx_byte !== txe[i]) begin failures++; $display("FAIL mid_tx_byte%0d got v=%b b=%h exp 1/%h", i, u_if.tx_valid, u_if.tx_byte, txe[i]); end
            checks++;
            if (wr !== (i == 3)) begin failures++; $display("FAIL mid_rx_write%0d got=%b exp=%b", i, wr, (i == 3)); end
            if (i == 3) begin
                checks++;
                if (dout !== 32'hA1B2C3D4) begin failures++; $display("FAIL mid_rx_word got=%h exp=a1b2c3d4", dout); end
            end
            step();
        end
        @(negedge clk);
        checks++; if (u_if.tx_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mid_final_idle got v=%b busy=%b exp 0/0", u_if.tx_valid, busy); end
        step();
    endtask

    initial begin
        test_reset();
        test_tx_lsb();
        test_back_to_back();
        test_rx_msb();
        test_rx_backpressure();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
